// File: rtl/noc_mem_pkg.sv
// Shared definitions for the data-memory arbiter and related NoC memory blocks.
package noc_mem_pkg;

  localparam int unsigned DefaultAddrW = 32;
  localparam int unsigned DefaultDataW = 32;

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StWait = 2'd1,
    StResp = 2'd2
  } arb_state_e;

endpackage

// File: rtl/dmem_arbiter_if.sv
// Core-side request/response bus plus memory-side port of the data-memory arbiter.
interface dmem_arbiter_if
  import noc_mem_pkg::*;
#(
  parameter int unsigned N_CORES = 4,
  parameter int unsigned ADDR_W  = DefaultAddrW,
  parameter int unsigned DATA_W  = DefaultDataW
);

  logic [N_CORES-1:0]        req_valid;
  logic [N_CORES-1:0]        req_we;
  logic [N_CORES*ADDR_W-1:0] req_addr;
  logic [N_CORES*DATA_W-1:0] req_wdata;
  logic [N_CORES-1:0]        req_ready;
  logic [N_CORES-1:0]        rsp_valid;
  logic [DATA_W-1:0]         rsp_rdata;
  logic                      mem_en;
  logic                      mem_we;
  logic [ADDR_W-1:0]         mem_addr;
  logic [DATA_W-1:0]         mem_wdata;
  logic [DATA_W-1:0]         mem_rdata;
  logic                      busy;

  // Arbiter side
  modport slave (
    input  req_valid, req_we, req_addr, req_wdata, mem_rdata,
    output req_ready, rsp_valid, rsp_rdata, mem_en, mem_we, mem_addr, mem_wdata, busy
  );

  // Cores plus memory side
  modport master (
    output req_valid, req_we, req_addr, req_wdata, mem_rdata,
    input  req_ready, rsp_valid, rsp_rdata, mem_en, mem_we, mem_addr, mem_wdata, busy
  );

endinterface

// File: rtl/rr_arbiter.sv
// Combinational rotating-priority selector: first request at or above ptr, wrapping.
module rr_arbiter #(
  parameter int unsigned N_CORES = 4
) (
  input  logic [N_CORES-1:0]         req,
  input  logic [$clog2(N_CORES)-1:0] ptr,
  output logic [N_CORES-1:0]         gnt,
  output logic [$clog2(N_CORES)-1:0] gnt_idx
);

  localparam int unsigned PtrW = $clog2(N_CORES);

  logic            found;
  int unsigned     sum;
  logic [PtrW-1:0] idx;

  // Scan upward from ptr modulo N_CORES; the first hit wins.
  always_comb begin
    gnt     = '0;
    gnt_idx = '0;
    found   = 1'b0;
    sum     = 0;
    idx     = '0;
    for (int unsigned off = 0; off < N_CORES; off++) begin
      sum = 32'(ptr) + off;
      if (sum >= N_CORES) begin
        sum = sum - N_CORES;
      end
      idx = PtrW'(sum);
      if (!found && req[idx]) begin
        found    = 1'b1;
        gnt[idx] = 1'b1;
        gnt_idx  = idx;
      end
    end
  end

endmodule

// File: rtl/dmem_arbiter.sv
// Round-robin arbiter sharing one fixed-latency data-memory port among N_CORES pipelines.
// N_CORES must be at least 2 and MEM_LAT at least 1.
module dmem_arbiter
  import noc_mem_pkg::*;
#(
  parameter int unsigned N_CORES = 4,
  parameter int unsigned ADDR_W  = DefaultAddrW,
  parameter int unsigned DATA_W  = DefaultDataW,
  parameter int unsigned MEM_LAT = 2
) (
  input logic           clk,
  input logic           rst,
  dmem_arbiter_if.slave bus
);

  localparam int unsigned       PtrW     = $clog2(N_CORES);
  localparam int unsigned       CntW     = $clog2(MEM_LAT + 1);
  localparam logic [CntW-1:0]   CntLoad  = CntW'(MEM_LAT - 1);
  localparam logic [CntW-1:0]   CntOne   = CntW'(1);
  localparam logic [PtrW-1:0]   LastCore = PtrW'(N_CORES - 1);
  localparam logic [N_CORES-1:0] OneHot0 = N_CORES'(1);

  arb_state_e      state_q;
  logic [PtrW-1:0] rr_ptr_q;
  logic [PtrW-1:0] owner_q;
  logic            owner_we_q;
  logic [CntW-1:0] cnt_q;

  logic [N_CORES-1:0] gnt;
  logic [PtrW-1:0]    gnt_idx;
  logic               accept;

  rr_arbiter #(
    .N_CORES (N_CORES)
  ) u_rr (
    .req     (bus.req_valid),
    .ptr     (rr_ptr_q),
    .gnt     (gnt),
    .gnt_idx (gnt_idx)
  );

  // Accept path and memory strobes; reset suppresses acceptance in the same cycle.
  always_comb begin
    accept        = (state_q == StIdle) && !rst && (|gnt);
    bus.req_ready = accept ? gnt : '0;
    bus.mem_en    = accept;
    bus.mem_we    = accept & bus.req_we[gnt_idx];
    bus.mem_addr  = accept ? bus.req_addr[32'(gnt_idx) * ADDR_W +: ADDR_W] : '0;
    bus.mem_wdata = accept ? bus.req_wdata[32'(gnt_idx) * DATA_W +: DATA_W] : '0;
  end

  // Response and status decode from registered state.
  always_comb begin
    bus.busy      = (state_q != StIdle);
    bus.rsp_valid = (state_q == StResp && !rst) ? (OneHot0 << owner_q) : '0;
    // Read data is meaningless for writes, so keep the shared bus quiet then.
    bus.rsp_rdata = (state_q == StResp && !rst && !owner_we_q) ? bus.mem_rdata : '0;
  end

  // Transaction FSM: grant in IDLE, count latency in WAIT, complete in RESP.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= StIdle;
      rr_ptr_q   <= '0;
      owner_q    <= '0;
      owner_we_q <= 1'b0;
      cnt_q      <= '0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (accept) begin
            owner_q    <= gnt_idx;
            owner_we_q <= bus.req_we[gnt_idx];
            rr_ptr_q   <= (gnt_idx == LastCore) ? '0 : gnt_idx + PtrW'(1);
            cnt_q      <= CntLoad;
            state_q    <= (MEM_LAT > 1) ? StWait : StResp;
          end
        end
        StWait: begin
          cnt_q <= cnt_q - CntOne;
          // Counter holds 1 on the last wait cycle, so RESP lands at accept + MEM_LAT.
          if (cnt_q <= CntOne) begin
            state_q <= StResp;
          end
        end
        StResp: begin
          state_q <= StIdle;
        end
        default: begin
          state_q <= StIdle;
        end
      endcase
    end
  end

endmodule
